// File: rtl/api_chain_engine.sv
// -----------------------------------------------------------------------------
// api_chain_engine
//   Moves one work at a time from the API TX word FIFO to one of CH_NUM
//   daisy-chained ASIC ports. For each word: pop TX, shift the word out MSB
//   first on mosi/sck while capturing the granted channel's miso, push the
//   captured word to RX. After the last word, the channel's load line is
//   pulsed. Channels are served round-robin over cfg_ch_mask. A work starts
//   only when TX holds a full work and RX has room for a full reply.
//
// Ports
//   CLK_I, RST_I      clock, synchronous active-high reset
//   cfg_ch_mask       channel enable mask (bit i = channel i)
//   cfg_word_num      words per work (0 blocks dispatch)
//   cfg_sck_div       sck half-period = cfg_sck_div+1 clocks
//   tx_count/rx_count FIFO fill levels, only looked at while idle
//   tx_rd_en/tx_dout  TX pop strobe; data valid the cycle after the pop
//   rx_wr_en/rx_din   RX push strobe and captured word
//   load              per-channel load strobe
//   sck/mosi/miso     shared serial clock/data out, per-channel data in
//   busy, cur_ch      activity flag, channel in progress / last served
//   work_done         one-cycle pulse after the load pulse
// -----------------------------------------------------------------------------
module api_chain_engine #(
    parameter int CH_NUM   = 16,
    parameter int WORD_W   = 32,
    parameter int CNT_W    = 10,
    parameter int RX_DEPTH = 512
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic [CH_NUM-1:0] cfg_ch_mask,
    input  logic [7:0]        cfg_word_num,
    input  logic [7:0]        cfg_sck_div,
    input  logic [CNT_W-1:0]  tx_count,
    output logic              tx_rd_en,
    input  logic [WORD_W-1:0] tx_dout,
    input  logic [CNT_W-1:0]  rx_count,
    output logic              rx_wr_en,
    output logic [WORD_W-1:0] rx_din,
    output logic [CH_NUM-1:0] load,
    output logic              sck,
    output logic              mosi,
    input  logic [CH_NUM-1:0] miso,
    output logic              busy,
    output logic [4:0]        cur_ch,
    output logic              work_done
);

    localparam int          BIT_W      = $clog2(WORD_W + 1);
    localparam logic [31:0] RX_DEPTH_U = 32'(RX_DEPTH);
    localparam logic [4:0]  LAST_CH    = 5'(CH_NUM - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_SHIFT, S_STORE, S_LOAD, S_GAP
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [4:0]          r_ch;
    logic [7:0]          r_words;
    logic [7:0]          r_div;
    logic [7:0]          r_div_cnt;
    logic [8:0]          r_load_cnt;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [7:0]          r_word_cnt;
    logic [WORD_W-1:0]   r_shift;
    logic [WORD_W-1:0]   r_cap;
    logic                r_sck;
    logic                r_mosi;
    logic                r_busy;
    logic                r_tx_rd_en;
    logic                r_rx_wr_en;
    logic                r_work_done;
    logic [CH_NUM-1:0]   r_load;
    logic [WORD_W-1:0]   r_rx_din;

    logic [31:0]         w_tx_cnt;
    logic [31:0]         w_rx_used;
    logic [31:0]         w_rx_free;
    logic [31:0]         w_words;
    logic                w_dispatch;
    logic [4:0]          w_grant;
    logic [31:0]         w_miso_ext;
    logic [31:0]         w_onehot;
    logic                w_miso_bit;
    logic                w_half_end;
    logic                w_last_bit;
    logic                w_load_end;

    // Round-robin: first enabled channel strictly after cur, wrapping; cur itself last.
    function automatic logic [4:0] f_next_ch(input logic [4:0] cur, input logic [CH_NUM-1:0] mask);
        logic [31:0] mask_ext;
        logic [4:0]  sel;
        logic        found;
        int          idx;
        mask_ext               = 32'd0;
        mask_ext[CH_NUM-1:0]   = mask;
        sel                    = cur;
        found                  = 1'b0;
        for (int i = 1; i <= CH_NUM; i++) begin
            idx = int'(cur) + i;
            if (idx >= CH_NUM) begin
                idx = idx - CH_NUM;
            end
            if (!found && mask_ext[5'(idx)]) begin
                sel   = 5'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign w_tx_cnt   = 32'(tx_count);
    assign w_rx_used  = 32'(rx_count);
    assign w_words    = 32'(cfg_word_num);
    assign w_grant    = f_next_ch(r_ch, cfg_ch_mask);
    assign w_onehot   = 32'd1 << r_ch;
    assign w_miso_bit = w_miso_ext[r_ch];
    assign w_half_end = (r_div_cnt == r_div);
    assign w_last_bit = (r_bit_cnt == BIT_W'(WORD_W - 1));
    assign w_load_end = (r_load_cnt == {r_div, 1'b1});

    // Free RX space, clamped so an over-reported count never wraps into "room".
    always_comb begin
        if (w_rx_used > RX_DEPTH_U) begin
            w_rx_free = 32'd0;
        end else begin
            w_rx_free = RX_DEPTH_U - w_rx_used;
        end
    end

    // Zero-extended miso so the 5-bit channel index never selects past the port.
    always_comb begin
        w_miso_ext             = 32'd0;
        w_miso_ext[CH_NUM-1:0] = miso;
    end

    assign w_dispatch = (cfg_word_num != 8'd0) && (cfg_ch_mask != '0) &&
                        (w_tx_cnt >= w_words) && (w_rx_free >= w_words);

    // State register.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_dispatch) w_next = S_FETCH;
                else            w_next = S_IDLE;
            end
            S_FETCH: w_next = S_WAIT;
            S_WAIT:  w_next = S_SHIFT;
            S_SHIFT: begin
                if (w_half_end && r_sck && w_last_bit) w_next = S_STORE;
                else                                   w_next = S_SHIFT;
            end
            S_STORE: begin
                if (r_word_cnt == r_words - 8'd1) w_next = S_LOAD;
                else                              w_next = S_FETCH;
            end
            S_LOAD: begin
                if (w_load_end) w_next = S_GAP;
                else            w_next = S_LOAD;
            end
            S_GAP:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath and registered outputs; strobes follow the state being entered.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_ch        <= LAST_CH;
            r_words     <= 8'd0;
            r_div       <= 8'd0;
            r_div_cnt   <= 8'd0;
            r_load_cnt  <= 9'd0;
            r_bit_cnt   <= '0;
            r_word_cnt  <= 8'd0;
            r_shift     <= '0;
            r_cap       <= '0;
            r_sck       <= 1'b0;
            r_mosi      <= 1'b0;
            r_busy      <= 1'b0;
            r_tx_rd_en  <= 1'b0;
            r_rx_wr_en  <= 1'b0;
            r_work_done <= 1'b0;
            r_load      <= '0;
            r_rx_din    <= '0;
        end else begin
            r_busy      <= (w_next != S_IDLE);
            r_tx_rd_en  <= (w_next == S_FETCH);
            r_rx_wr_en  <= (w_next == S_STORE);
            r_work_done <= (w_next == S_GAP);
            r_load      <= (w_next == S_LOAD) ? w_onehot[CH_NUM-1:0] : '0;
            case (r_state)
                S_IDLE: begin
                    // Work parameters are frozen here; later cfg edits apply to the next work.
                    if (w_dispatch) begin
                        r_ch       <= w_grant;
                        r_words    <= cfg_word_num;
                        r_div      <= cfg_sck_div;
                        r_word_cnt <= 8'd0;
                    end
                end
                S_WAIT: begin
                    r_shift   <= tx_dout;
                    r_mosi    <= tx_dout[WORD_W-1];
                    r_sck     <= 1'b0;
                    r_div_cnt <= 8'd0;
                    r_bit_cnt <= '0;
                end
                S_SHIFT: begin
                    if (w_half_end) begin
                        r_div_cnt <= 8'd0;
                        if (!r_sck) begin
                            // Rising sck: sample the granted channel.
                            r_sck <= 1'b1;
                            r_cap <= {r_cap[WORD_W-2:0], w_miso_bit};
                        end else begin
                            // Falling sck: advance to the next bit.
                            r_sck     <= 1'b0;
                            r_shift   <= {r_shift[WORD_W-2:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                            if (w_last_bit) begin
                                r_mosi   <= 1'b0;
                                r_rx_din <= r_cap;
                            end else begin
                                r_mosi <= r_shift[WORD_W-2];
                            end
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                    end
                end
                S_STORE: begin
                    r_word_cnt <= r_word_cnt + 8'd1;
                    r_load_cnt <= 9'd0;
                end
                S_LOAD: begin
                    r_load_cnt <= r_load_cnt + 9'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign tx_rd_en  = r_tx_rd_en;
    assign rx_wr_en  = r_rx_wr_en;
    assign rx_din    = r_rx_din;
    assign load      = r_load;
    assign sck       = r_sck;
    assign mosi      = r_mosi;
    assign busy      = r_busy;
    assign cur_ch    = r_ch;
    assign work_done = r_work_done;

endmodule
